core_sequencer: RTL and testbench

Parametrised multi-cycle control sequencer for the Trashbin RV32 core. It replaces the fixed 5-phase counter with a handshake-driven state machine. It owns the program counter, the instruction register, the register-file write strobe, and the memory bus. It sits between the memory interface and the existing decoder / ALU / register file, which stay outside and feed it decoded control signals. New behaviour over the old counter:
- wait states on load/store;
- byte lanes;
- sign-extended loads;
- bus timeout;
- a sticky halt with a trap cause.

---
 rtl/trashbin_pkg.sv | 28 ++
 rtl/core_sequencer_if.sv | 30 +++
 rtl/core_sequencer_load_store_lane.sv | 59 +++++
 rtl/core_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_core_sequencer.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/trashbin_pkg.sv
// trashbin_pkg
// Shared types and constants for the Trashbin RV32 control sequencer:
// FSM state encoding, trap-cause codes, memory access width encodings
// and the reset value of the instruction register.
package trashbin_pkg;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_EXEC  = 3'd1,
    ST_MEM   = 3'd2,
    ST_WB    = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  localparam logic [1:0] TRAP_NONE     = 2'd0;
  localparam logic [1:0] TRAP_ILLEGAL  = 2'd1;
  localparam logic [1:0] TRAP_MISALIGN = 2'd2;
  localparam logic [1:0] TRAP_TIMEOUT  = 2'd3;

  localparam logic [1:0] MW_BYTE    = 2'b00;
  localparam logic [1:0] MW_HALF    = 2'b01;
  localparam logic [1:0] MW_WORD    = 2'b10;
  localparam logic [1:0] MW_ILLEGAL = 2'b11;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/core_sequencer_if.sv
// core_sequencer_if
// Memory bus between the sequencer (master) and the memory (slave).
//   AddressBus   : word-aligned address for data accesses, PC for fetches
//   ByteEnable   : active byte lanes
//   DataWriteBus : store data, replicated across lanes
//   ReadAssert   : read request, held until ReadOK
//   WriteAssert  : write request, held until WriteOK
//   DataReadBus  : read data, valid while ReadOK is high
//   ReadOK       : read complete
//   WriteOK      : write complete
interface core_sequencer_if;
  logic [31:0] AddressBus;
  logic [3:0]  ByteEnable;
  logic [31:0] DataWriteBus;
  logic        ReadAssert;
  logic        WriteAssert;
  logic [31:0] DataReadBus;
  logic        ReadOK;
  logic        WriteOK;

  modport master (
    output AddressBus, ByteEnable, DataWriteBus, ReadAssert, WriteAssert,
    input  DataReadBus, ReadOK, WriteOK
  );

  modport slave (
    input  AddressBus, ByteEnable, DataWriteBus, ReadAssert, WriteAssert,
    output DataReadBus, ReadOK, WriteOK
  );
endinterface

// File: rtl/core_sequencer_load_store_lane.sv
// load_store_lane
// Combinational byte-lane logic for loads and stores.
//   addr_i     : low two bits of the effective address
//   width_i    : access width (byte / half / word / illegal)
//   sign_ext_i : sign-extend narrow loads when set
//   wsrc_i     : store source register value
//   rdata_i    : raw memory read word
//   byte_en_o  : active byte lanes
//   wdata_o    : store data replicated across lanes
//   rdata_o    : extracted and extended load value
//   misalign_o : access not naturally aligned
module load_store_lane
  import trashbin_pkg::*;
(
  input  logic [1:0]  addr_i,
  input  logic [1:0]  width_i,
  input  logic        sign_ext_i,
  input  logic [31:0] wsrc_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  byte_en_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign rd_byte = rdata_i[{addr_i, 3'b000} +: 8];
  assign rd_half = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    byte_en_o  = 4'b0000;
    wdata_o    = wsrc_i;
    rdata_o    = rdata_i;
    misalign_o = 1'b0;
    case (width_i)
      MW_BYTE: begin
        byte_en_o = 4'b0001 << addr_i;
        wdata_o   = {4{wsrc_i[7:0]}};
        rdata_o   = {{24{sign_ext_i & rd_byte[7]}}, rd_byte};
      end
      MW_HALF: begin
        byte_en_o  = 4'b0011 << addr_i;
        wdata_o    = {2{wsrc_i[15:0]}};
        rdata_o    = {{16{sign_ext_i & rd_half[15]}}, rd_half};
        misalign_o = addr_i[0];
      end
      MW_WORD: begin
        byte_en_o  = 4'b1111;
        misalign_o = |addr_i;
      end
      default: begin
        byte_en_o = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/core_sequencer.sv
// core_sequencer
// Handshake-driven multi-cycle control sequencer for the Trashbin RV32 core.
// Owns PC, instruction register, register-file write strobe and memory bus.
//   CoreClock / CoreResetN : clock (rising edge) and async active-low reset
//   bus                    : memory bus master (address, lanes, data, handshakes)
//   CurrentInstruction     : instruction register, to the decoder
//   ProgramCounter         : current PC
//   Invalid.. DecodedImediate, RegisterReadPortA/B, ALU_Result : decoder/ALU/regfile inputs
//   RegisterWriteEnable / RegisterWriteData : one-cycle write-back strobe and data
//   Halted / TrapCause     : sticky halt and its reason
//
// state | meaning
// FETCH | read instruction at PC, wait for ReadOK
// EXEC  | decoder/ALU settle for EXEC_CYCLES, then trap/MEM/WB decision
// MEM   | one load or store on the bus, wait for ReadOK/WriteOK
// WB    | register write strobe and PC update
// HALT  | sticky trap, everything frozen until reset
module core_sequencer
  import trashbin_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned EXEC_CYCLES    = 1
) (
  input  logic             CoreClock,
  input  logic             CoreResetN,
  core_sequencer_if.master bus,
  output logic [31:0]      CurrentInstruction,
  output logic [31:0]      ProgramCounter,
  input  logic             InvalidInstruction,
  input  logic             IsBranchInstruction,
  input  logic             IsBranchTaken,
  input  logic             IsJumpInstruction,
  input  logic             JumpMode,
  input  logic             IsMemoryRead,
  input  logic             IsMemoryWrite,
  input  logic [1:0]       MemoryAccessWidth,
  input  logic             MemoryAccessSignExtend,
  input  logic             WritesRegisterFile,
  input  logic [31:0]      DecodedImediate,
  input  logic [31:0]      RegisterReadPortA,
  input  logic [31:0]      RegisterReadPortB,
  input  logic [31:0]      ALU_Result,
  output logic             RegisterWriteEnable,
  output logic [31:0]      RegisterWriteData,
  output logic             Halted,
  output logic [1:0]       TrapCause
);

  localparam logic [1:0]  EXEC_LAST = 2'(EXEC_CYCLES - 1);
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [15:0] wait_q, wait_d;
  logic [1:0]  exec_q, exec_d;
  logic [31:0] load_q, load_d;
  logic [1:0]  cause_q, cause_d;

  logic        read_req, write_req;
  logic [31:0] addr_out;
  logic [3:0]  be_out;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_rdata;
  logic        lane_misalign;
  logic        mem_op, mem_ok;
  logic [31:0] target;

  load_store_lane u_lane (
    .addr_i     (ALU_Result[1:0]),
    .width_i    (MemoryAccessWidth),
    .sign_ext_i (MemoryAccessSignExtend),
    .wsrc_i     (RegisterReadPortB),
    .rdata_i    (bus.DataReadBus),
    .byte_en_o  (lane_be),
    .wdata_o    (lane_wdata),
    .rdata_o    (lane_rdata),
    .misalign_o (lane_misalign)
  );

  assign mem_op = IsMemoryRead | IsMemoryWrite;
  assign mem_ok = IsMemoryRead ? bus.ReadOK : bus.WriteOK;

  always_comb begin
    if (IsJumpInstruction && JumpMode)
      target = (RegisterReadPortA + DecodedImediate) & ~32'd1;
    else if (IsJumpInstruction || (IsBranchInstruction && IsBranchTaken))
      target = pc_q + DecodedImediate;
    else
      target = pc_q + 32'd4;
  end

  always_ff @(posedge CoreClock or negedge CoreResetN) begin
    if (!CoreResetN) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_VECTOR;
      ir_q    <= NOP_INSTR;
      wait_q  <= 16'd0;
      exec_q  <= 2'd0;
      load_q  <= 32'd0;
      cause_q <= TRAP_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      wait_q  <= wait_d;
      exec_q  <= exec_d;
      load_q  <= load_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    pc_d                = pc_q;
    ir_d                = ir_q;
    wait_d              = wait_q;
    exec_d              = exec_q;
    load_d              = load_q;
    cause_d             = cause_q;
    read_req            = 1'b0;
    write_req           = 1'b0;
    addr_out            = pc_q;
    be_out              = 4'b0000;
    RegisterWriteEnable = 1'b0;

    case (state_q)
      ST_FETCH: begin
        read_req = 1'b1;
        be_out   = 4'b1111;
        if (bus.ReadOK) begin
          ir_d    = bus.DataReadBus;
          state_d = ST_EXEC;
          exec_d  = 2'd0;
          wait_d  = 16'd0;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_HALT;
          cause_d = TRAP_TIMEOUT;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end

      ST_EXEC: begin
        if (exec_q != EXEC_LAST) begin
          exec_d = exec_q + 2'd1;
        end else if (InvalidInstruction || (mem_op && MemoryAccessWidth == MW_ILLEGAL)) begin
          state_d = ST_HALT;
          cause_d = TRAP_ILLEGAL;
        end else if (mem_op && lane_misalign) begin
          state_d = ST_HALT;
          cause_d = TRAP_MISALIGN;
        end else if (mem_op) begin
          state_d = ST_MEM;
          wait_d  = 16'd0;
        end else begin
          state_d = ST_WB;
        end
      end

      ST_MEM: begin
        addr_out  = {ALU_Result[31:2], 2'b00};
        be_out    = lane_be;
        read_req  = IsMemoryRead;
        write_req = ~IsMemoryRead;
        if (mem_ok) begin
          load_d  = lane_rdata;
          state_d = ST_WB;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_HALT;
          cause_d = TRAP_TIMEOUT;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end

      ST_WB: begin
        RegisterWriteEnable = WritesRegisterFile;
        // The register write still happens when the new PC traps.
        if (target[1]) begin
          state_d = ST_HALT;
          cause_d = TRAP_MISALIGN;
        end else begin
          pc_d    = target;
          state_d = ST_FETCH;
          wait_d  = 16'd0;
        end
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  // Requests are gated by reset so they fall the moment reset asserts,
  // even though the state register itself parks in FETCH.
  assign bus.ReadAssert   = read_req & CoreResetN;
  assign bus.WriteAssert  = write_req & CoreResetN;
  assign bus.AddressBus   = addr_out;
  assign bus.ByteEnable   = be_out & {4{CoreResetN}};
  assign bus.DataWriteBus = lane_wdata;

  assign RegisterWriteData  = IsMemoryRead ? load_q : ALU_Result;
  assign CurrentInstruction = ir_q;
  assign ProgramCounter     = pc_q;
  assign Halted             = (state_q == ST_HALT);
  assign TrapCause          = cause_q;

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer
// Directed bench: instance A (reset vector 0, timeout 255) covers fetch,
// loads, stores, misalignment and control flow; instance B (reset vector
// 0x1000, timeout 4) covers the bus timeout and reset during a data access.
module tb_core_sequencer;

  logic        clk;
  logic        rst_a, rst_b;
  logic        inv, is_br, br_taken, is_jmp, jmode, mrd, mwr, msext, wrf;
  logic [1:0]  mwidth;
  logic [31:0] imm, rs1, rs2, alu;

  logic [31:0] a_ir, a_pc, a_rwd, b_ir, b_pc, b_rwd;
  logic        a_rwe, a_halt, b_rwe, b_halt;
  logic [1:0]  a_cause, b_cause;

  int tests  = 0;
  int failed = 0;

  core_sequencer_if ifa ();
  core_sequencer_if ifb ();

  initial clk = 1'b0;
  always #5 clk = ~clk;

  core_sequencer #(.RESET_VECTOR(32'h0000_0000), .TIMEOUT_CYCLES(255), .EXEC_CYCLES(1)) dut_a (
    .CoreClock(clk), .CoreResetN(rst_a), .bus(ifa),
    .CurrentInstruction(a_ir), .ProgramCounter(a_pc),
    .InvalidInstruction(inv), .IsBranchInstruction(is_br), .IsBranchTaken(br_taken),
    .IsJumpInstruction(is_jmp), .JumpMode(jmode), .IsMemoryRead(mrd), .IsMemoryWrite(mwr),
    .MemoryAccessWidth(mwidth), .MemoryAccessSignExtend(msext), .WritesRegisterFile(wrf),
    .DecodedImediate(imm), .RegisterReadPortA(rs1), .RegisterReadPortB(rs2), .ALU_Result(alu),
    .RegisterWriteEnable(a_rwe), .RegisterWriteData(a_rwd), .Halted(a_halt), .TrapCause(a_cause)
  );

  core_sequencer #(.RESET_VECTOR(32'h0000_1000), .TIMEOUT_CYCLES(4), .EXEC_CYCLES(1)) dut_b (
    .CoreClock(clk), .CoreResetN(rst_b), .bus(ifb),
    .CurrentInstruction(b_ir), .ProgramCounter(b_pc),
    .InvalidInstruction(inv), .IsBranchInstruction(is_br), .IsBranchTaken(br_taken),
    .IsJumpInstruction(is_jmp), .JumpMode(jmode), .IsMemoryRead(mrd), .IsMemoryWrite(mwr),
    .MemoryAccessWidth(mwidth), .MemoryAccessSignExtend(msext), .WritesRegisterFile(wrf),
    .DecodedImediate(imm), .RegisterReadPortA(rs1), .RegisterReadPortB(rs2), .ALU_Result(alu),
    .RegisterWriteEnable(b_rwe), .RegisterWriteData(b_rwd), .Halted(b_halt), .TrapCause(b_cause)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_dec();
    inv = 0; is_br = 0; br_taken = 0; is_jmp = 0; jmode = 0;
    mrd = 0; mwr = 0; msext = 0; wrf = 0; mwidth = 2'b10;
    imm = 0; rs1 = 0; rs2 = 0; alu = 0;
  endtask

  // Complete a zero-wait fetch on A; leaves A in EXEC.
  task automatic fetch_a(input logic [31:0] instr);
    ifa.DataReadBus = instr; ifa.ReadOK = 1;
    tick();
    ifa.ReadOK = 0; ifa.DataReadBus = 0;
  endtask

  task automatic fetch_b(input logic [31:0] instr);
    ifb.DataReadBus = instr; ifb.ReadOK = 1;
    tick();
    ifb.ReadOK = 0; ifb.DataReadBus = 0;
  endtask

  task automatic test_reset();
    tests++; if (a_pc !== 32'h0) begin failed++; $display("FAIL rst_pc got=%h exp=%h", a_pc, 32'h0); end
    tests++; if (a_ir !== 32'h13) begin failed++; $display("FAIL rst_ir got=%h exp=%h", a_ir, 32'h13); end
    tests++; if (ifa.ReadAssert !== 1'b0 || ifa.WriteAssert !== 1'b0) begin failed++; $display("FAIL rst_strobes got=%b%b exp=00", ifa.ReadAssert, ifa.WriteAssert); end
    tests++; if (a_halt !== 1'b0 || a_cause !== 2'd0) begin failed++; $display("FAIL rst_halt got=%b/%0d exp=0/0", a_halt, a_cause); end
    tests++; if (a_rwe !== 1'b0) begin failed++; $display("FAIL rst_rwe got=%b exp=0", a_rwe); end
  endtask

  task automatic test_addi();
    tick(); rst_a = 1; #1;
    clear_dec(); wrf = 1; imm = 5; alu = 5;
    tests++; if (ifa.ReadAssert !== 1'b1 || ifa.AddressBus !== 32'h0 || ifa.ByteEnable !== 4'b1111) begin failed++; $display("FAIL addi_fetch got=%b/%h/%b exp=1/0/1111", ifa.ReadAssert, ifa.AddressBus, ifa.ByteEnable); end
    fetch_a(32'h0050_0093);
    tests++; if (a_ir !== 32'h0050_0093) begin failed++; $display("FAIL addi_ir got=%h exp=00500093", a_ir); end
    tests++; if (a_rwe !== 1'b0) begin failed++; $display("FAIL addi_exec_rwe got=%b exp=0", a_rwe); end
    tick();
    tests++; if (a_rwe !== 1'b1 || a_rwd !== 32'd5) begin failed++; $display("FAIL addi_wb got=%b/%h exp=1/5", a_rwe, a_rwd); end
    tick();
    tests++; if (ifa.AddressBus !== 32'h4 || ifa.ReadAssert !== 1'b1 || a_rwe !== 1'b0) begin failed++; $display("FAIL addi_next got=%h/%b/%b exp=4/1/0", ifa.AddressBus, ifa.ReadAssert, a_rwe); end
  endtask

  task automatic test_load_byte();
    clear_dec(); mrd = 1; mwidth = 2'b00; msext = 1; wrf = 1; alu = 32'h103;
    fetch_a(32'h1030_0083);
    tick();
    tests++; if (ifa.AddressBus !== 32'h100 || ifa.ByteEnable !== 4'b1000) begin failed++; $display("FAIL lb_bus got=%h/%b exp=100/1000", ifa.AddressBus, ifa.ByteEnable); end
    tests++; if (ifa.ReadAssert !== 1'b1 || ifa.WriteAssert !== 1'b0) begin failed++; $display("FAIL lb_req got=%b%b exp=10", ifa.ReadAssert, ifa.WriteAssert); end
    for (int i = 0; i < 3; i++) tick();
    tests++; if (ifa.ReadAssert !== 1'b1) begin failed++; $display("FAIL lb_hold got=%b exp=1", ifa.ReadAssert); end
    ifa.DataReadBus = 32'h8000_0000; ifa.ReadOK = 1;
    tick();
    ifa.ReadOK = 0; ifa.DataReadBus = 0;
    tests++; if (a_rwe !== 1'b1 || a_rwd !== 32'hFFFF_FF80) begin failed++; $display("FAIL lb_data got=%b/%h exp=1/ffffff80", a_rwe, a_rwd); end
    tick();
    msext = 0;
    fetch_a(32'h1030_4083);
    tick();
    ifa.DataReadBus = 32'h8000_0000; ifa.ReadOK = 1;
    tick();
    ifa.ReadOK = 0; ifa.DataReadBus = 0;
    tests++; if (a_rwd !== 32'h0000_0080) begin failed++; $display("FAIL lbu_data got=%h exp=00000080", a_rwd); end
    tick();
    tests++; if (a_pc !== 32'hC) begin failed++; $display("FAIL lb_pc got=%h exp=0000000c", a_pc); end
  endtask

  task automatic test_store_half();
    clear_dec(); mwr = 1; mwidth = 2'b01; rs2 = 32'h1234_ABCD; alu = 32'h202;
    fetch_a(32'h0020_1123);
    tick();
    tests++; if (ifa.ByteEnable !== 4'b1100 || ifa.DataWriteBus !== 32'hABCD_ABCD || ifa.AddressBus !== 32'h200) begin failed++; $display("FAIL sh_bus got=%b/%h/%h exp=1100/abcdabcd/200", ifa.ByteEnable, ifa.DataWriteBus, ifa.AddressBus); end
    tests++; if (ifa.WriteAssert !== 1'b1 || ifa.ReadAssert !== 1'b0) begin failed++; $display("FAIL sh_req got=%b%b exp=01", ifa.ReadAssert, ifa.WriteAssert); end
    tick(); tick();
    tests++; if (ifa.WriteAssert !== 1'b1) begin failed++; $display("FAIL sh_hold got=%b exp=1", ifa.WriteAssert); end
    ifa.WriteOK = 1;
    tick();
    ifa.WriteOK = 0;
    tests++; if (ifa.WriteAssert !== 1'b0 || a_rwe !== 1'b0) begin failed++; $display("FAIL sh_wb got=%b/%b exp=0/0", ifa.WriteAssert, a_rwe); end
    tick();
    tests++; if (a_pc !== 32'h10) begin failed++; $display("FAIL sh_pc got=%h exp=00000010", a_pc); end
  endtask

  task automatic test_misaligned_load();
    clear_dec(); mrd = 1; mwidth = 2'b10; wrf = 1; alu = 32'h101;
    fetch_a(32'h1010_2083);
    tick();
    tests++; if (a_halt !== 1'b1 || a_cause !== 2'd2) begin failed++; $display("FAIL lw_mis_halt got=%b/%0d exp=1/2", a_halt, a_cause); end
    tests++; if (ifa.ReadAssert !== 1'b0 || ifa.WriteAssert !== 1'b0 || a_rwe !== 1'b0) begin failed++; $display("FAIL lw_mis_strobe got=%b%b%b exp=000", ifa.ReadAssert, ifa.WriteAssert, a_rwe); end
    ifa.ReadOK = 1; ifa.DataReadBus = 32'hDEAD_BEEF;
    tick(); tick();
    ifa.ReadOK = 0; ifa.DataReadBus = 0;
    tests++; if (a_pc !== 32'h10 || a_ir !== 32'h1010_2083 || a_halt !== 1'b1) begin failed++; $display("FAIL lw_mis_frozen got=%h/%h/%b exp=10/10102083/1", a_pc, a_ir, a_halt); end
  endtask

  task automatic test_control_flow();
    rst_a = 0; #1;
    tick(); rst_a = 1; #1;
    clear_dec(); is_br = 1; br_taken = 1; imm = 32'h40;
    fetch_a(32'h0400_0063);
    tick(); tick();
    tests++; if (a_pc !== 32'h40 || ifa.AddressBus !== 32'h40) begin failed++; $display("FAIL br_target got=%h/%h exp=40/40", a_pc, ifa.AddressBus); end
    clear_dec(); is_jmp = 1; jmode = 1; rs1 = 32'h100; imm = 32'h23; wrf = 1; alu = 32'h44;
    fetch_a(32'h0230_80E7);
    tick();
    tests++; if (a_rwe !== 1'b1 || a_rwd !== 32'h44) begin failed++; $display("FAIL jalr_link got=%b/%h exp=1/44", a_rwe, a_rwd); end
    tick();
    tests++; if (a_halt !== 1'b1 || a_cause !== 2'd2 || a_pc !== 32'h40) begin failed++; $display("FAIL jalr_mis got=%b/%0d/%h exp=1/2/40", a_halt, a_cause, a_pc); end
  endtask

  task automatic test_timeout();
    clear_dec();
    tick(); rst_b = 1; #1;
    tests++; if (ifb.ReadAssert !== 1'b1 || ifb.AddressBus !== 32'h1000) begin failed++; $display("FAIL to_fetch got=%b/%h exp=1/1000", ifb.ReadAssert, ifb.AddressBus); end
    tick(); tick(); tick();
    tests++; if (b_halt !== 1'b0 || ifb.ReadAssert !== 1'b1) begin failed++; $display("FAIL to_early got=%b/%b exp=0/1", b_halt, ifb.ReadAssert); end
    tick();
    tests++; if (b_halt !== 1'b1 || b_cause !== 2'd3 || ifb.ReadAssert !== 1'b0) begin failed++; $display("FAIL to_halt got=%b/%0d/%b exp=1/3/0", b_halt, b_cause, ifb.ReadAssert); end
  endtask

  task automatic test_reset_mid_mem();
    rst_b = 0; #1;
    tick(); rst_b = 1; #1;
    clear_dec(); wrf = 1; alu = 32'h7;
    fetch_b(32'h0070_0093);
    tick(); tick();
    tests++; if (b_pc !== 32'h1004) begin failed++; $display("FAIL rm_pc_adv got=%h exp=00001004", b_pc); end
    clear_dec(); mrd = 1; mwidth = 2'b10; wrf = 1; alu = 32'h20;
    fetch_b(32'h0200_2083);
    tick();
    tests++; if (ifb.ReadAssert !== 1'b1 || ifb.AddressBus !== 32'h20) begin failed++; $display("FAIL rm_mem got=%b/%h exp=1/20", ifb.ReadAssert, ifb.AddressBus); end
    tick();
    rst_b = 0; #1;
    tests++; if (ifb.ReadAssert !== 1'b0 || ifb.WriteAssert !== 1'b0) begin failed++; $display("FAIL rm_drop got=%b%b exp=00", ifb.ReadAssert, ifb.WriteAssert); end
    tests++; if (b_pc !== 32'h1000 || b_halt !== 1'b0 || b_cause !== 2'd0) begin failed++; $display("FAIL rm_state got=%h/%b/%0d exp=1000/0/0", b_pc, b_halt, b_cause); end
    tick(); rst_b = 1; #1;
    tests++; if (ifb.ReadAssert !== 1'b1 || ifb.AddressBus !== 32'h1000) begin failed++; $display("FAIL rm_refetch got=%b/%h exp=1/1000", ifb.ReadAssert, ifb.AddressBus); end
  endtask

  initial begin
    rst_a = 0; rst_b = 0;
    clear_dec();
    ifa.DataReadBus = 0; ifa.ReadOK = 0; ifa.WriteOK = 0;
    ifb.DataReadBus = 0; ifb.ReadOK = 0; ifb.WriteOK = 0;
    tick(); tick();
    test_reset();
    test_addi();
    test_load_byte();
    test_store_half();
    test_misaligned_load();
    test_control_flow();
    test_timeout();
    test_reset_mid_mem();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
